// File: rtl/spi_ctrl_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | spi_ctrl_tx : SPI mode-0 master, one byte out / one byte in per handshake.
// | Revision    : 1.0
// +-----------------------------------------------------------------------------
module spi_ctrl_tx #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_dat,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       miso,
   output logic       sclk,
   output logic       mosi,
   output logic       cs,
   output logic [7:0] rx_dat,
   output logic       done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SETUP = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   localparam logic [7:0] C_DIV_LAST = 8'(CLK_DIV - 1);

   logic [1:0] r_state;
   logic [7:0] r_div;
   logic [2:0] r_bit;
   logic [7:0] r_tx_sh;
   logic [7:0] r_rx_sh;

   logic       w_div_end;
   logic       w_accept;

   assign w_div_end = (r_div == C_DIV_LAST);
   assign w_accept  = (r_state == S_IDLE) && tx_valid && tx_ready;

   // Half-period divider: free-runs outside IDLE, wraps every CLK_DIV cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div <= 8'd0;
      end else if (r_state == S_IDLE || w_div_end) begin
         r_div <= 8'd0;
      end else begin
         r_div <= r_div + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_bit    <= 3'd0;
         r_tx_sh  <= 8'h00;
         r_rx_sh  <= 8'h00;
         tx_ready <= 1'b1;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         cs       <= 1'b1;
         rx_dat   <= 8'h00;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_tx_sh  <= tx_dat;
                  r_rx_sh  <= 8'h00;
                  r_bit    <= 3'd0;
                  mosi     <= tx_dat[7];
                  cs       <= 1'b0;
                  tx_ready <= 1'b0;
                  r_state  <= S_SETUP;
               end
            end

            // The SETUP exit edge is the first sclk rising edge, so bit 7 of miso is captured here.
            S_SETUP: begin
               if (w_div_end) begin
                  sclk    <= 1'b1;
                  r_rx_sh <= {r_rx_sh[6:0], miso};
                  r_state <= S_SHIFT;
               end
            end

            S_SHIFT: begin
               if (w_div_end) begin
                  if (sclk) begin
                     sclk  <= 1'b0;
                     r_bit <= r_bit + 3'd1;
                     if (r_bit == 3'd7) begin
                        r_state <= S_HOLD;
                     end else begin
                        mosi    <= r_tx_sh[6];
                        r_tx_sh <= {r_tx_sh[6:0], 1'b0};
                     end
                  end else begin
                     sclk    <= 1'b1;
                     r_rx_sh <= {r_rx_sh[6:0], miso};
                  end
               end
            end

            S_HOLD: begin
               if (w_div_end) begin
                  cs       <= 1'b1;
                  mosi     <= 1'b0;
                  rx_dat   <= r_rx_sh;
                  done     <= 1'b1;
                  tx_ready <= 1'b1;
                  r_state  <= S_IDLE;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_ctrl_tx.sv
`timescale 1ns/1ps
`default_nettype none
// tb_spi_ctrl_tx : scoreboarded bench for two spi_ctrl_tx instances (CLK_DIV 4 and 2).
module tb_spi_ctrl_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_v      [2];
   logic [7:0] tx_dat_v   [2];
   logic       tx_valid_v [2];
   logic       tx_ready_v [2];
   logic       miso_v     [2];
   logic       sclk_v     [2];
   logic       mosi_v     [2];
   logic       cs_v       [2];
   logic [7:0] rx_dat_v   [2];
   logic       done_v     [2];
   logic [7:0] slave_byte [2];
   logic       loop_v     [2];

   int n_pass  = 0;
   int n_total = 0;

   // Entries are {byte expected on mosi, byte expected on rx_dat}.
   logic [15:0] q0[$];
   logic [15:0] q1[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   function automatic int qsize(input int ln);
      return (ln == 0) ? q0.size() : q1.size();
   endfunction

   function automatic logic [15:0] qpop(input int ln);
      if (ln == 0) return q0.pop_front();
      return q1.pop_front();
   endfunction

   task automatic qpush(input int ln, input logic [15:0] v);
      if (ln == 0) q0.push_back(v);
      else         q1.push_back(v);
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_lane
      localparam int D = (g == 0) ? 4 : 2;

      spi_ctrl_tx #(.CLK_DIV(D)) u_dut (
         .clk      (clk),
         .rst      (rst_v[g]),
         .tx_dat   (tx_dat_v[g]),
         .tx_valid (tx_valid_v[g]),
         .tx_ready (tx_ready_v[g]),
         .miso     (miso_v[g]),
         .sclk     (sclk_v[g]),
         .mosi     (mosi_v[g]),
         .cs       (cs_v[g]),
         .rx_dat   (rx_dat_v[g]),
         .done     (done_v[g])
      );

      // Mode-0 peripheral: loads its byte when cs falls, shifts after each sclk fall.
      logic [7:0] slave_sh  = 8'h00;
      logic       sl_cs_q   = 1'b1;
      logic       sl_sclk_q = 1'b0;
      always @(posedge clk) begin
         if (sl_cs_q && !cs_v[g])           slave_sh <= slave_byte[g];
         else if (sl_sclk_q && !sclk_v[g])  slave_sh <= {slave_sh[6:0], 1'b0};
         sl_cs_q   <= cs_v[g];
         sl_sclk_q <= sclk_v[g];
      end
      assign miso_v[g] = loop_v[g] ? mosi_v[g] : slave_sh[7];

      // Monitor: receiver model plus frame-timing rules; pops the scoreboard on done.
      int         n = 0, rises = 0, viol = 0, hold_bad = 0;
      logic       in_frame = 1'b0, p_cs = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0, p_done = 1'b0;
      logic [7:0] rcv = 8'h00, last_rx = 8'h00;
      logic [15:0] e;
      always @(negedge clk) begin
         if (rst_v[g]) begin
            in_frame = 1'b0; last_rx = 8'h00; hold_bad = 0;
            p_cs = 1'b1; p_sclk = 1'b0; p_mosi = 1'b0; p_done = 1'b0;
         end else begin
            if (p_cs && !cs_v[g]) begin
               in_frame = 1'b1; n = 0; rises = 0; viol = 0; rcv = 8'h00;
            end else if (in_frame) begin
               n++;
            end
            if (cs_v[g] && sclk_v[g])             viol++;
            if (!cs_v[g] && tx_ready_v[g])        viol++;
            if (sclk_v[g] && mosi_v[g] !== p_mosi) viol++;
            if (!p_sclk && sclk_v[g]) begin
               if (n != D * (1 + 2 * rises)) viol++;
               rcv = {rcv[6:0], mosi_v[g]};
               rises++;
            end
            if (p_sclk && !sclk_v[g] && n != 2 * D * rises) viol++;
            if (!done_v[g] && rx_dat_v[g] !== last_rx) hold_bad++;
            if (done_v[g]) begin
               if (qsize(g) == 0) begin
                  n_total++;
                  $display("FAIL lane%0d_unexpected_done: got done with rx_dat=%02h, required no done", g, rx_dat_v[g]);
               end else begin
                  e = qpop(g);
                  chk($sformatf("lane%0d_mosi_byte", g), 32'(rcv), 32'(e[15:8]));
                  chk($sformatf("lane%0d_rx_dat", g), 32'(rx_dat_v[g]), 32'(e[7:0]));
                  chk($sformatf("lane%0d_frame_len", g), 32'(n), 32'(17 * D));
                  chk($sformatf("lane%0d_sclk_rises", g), 32'(rises), 32'd8);
                  chk($sformatf("lane%0d_protocol_viol", g), 32'(viol), 32'd0);
                  chk($sformatf("lane%0d_done_single", g), 32'(p_done), 32'd0);
                  chk($sformatf("lane%0d_rx_hold_viol", g), 32'(hold_bad), 32'd0);
               end
               hold_bad = 0;
               last_rx  = rx_dat_v[g];
               in_frame = 1'b0;
            end
            p_cs = cs_v[g]; p_sclk = sclk_v[g]; p_mosi = mosi_v[g]; p_done = done_v[g];
         end
      end
   end

   task automatic wait_ready(input int ln);
      int t;
      t = 0;
      while (tx_ready_v[ln] !== 1'b1 && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (t >= 400) begin
         n_total++;
         $display("FAIL lane%0d_ready_timeout: got tx_ready=%b after %0d cycles, required 1", ln, tx_ready_v[ln], t);
      end
   endtask

   task automatic send(input int ln, input logic [7:0] b, input logic [7:0] sb, input logic lb);
      wait_ready(ln);
      slave_byte[ln] = sb;
      loop_v[ln]     = lb;
      tx_dat_v[ln]   = b;
      tx_valid_v[ln] = 1'b1;
      @(posedge clk);
      #1;
      tx_valid_v[ln] = 1'b0;
      tx_dat_v[ln]   = 8'($urandom);
      qpush(ln, {b, lb ? b : sb});
   endtask

   task automatic chk_idle_outputs(input string tag, input int ln);
      chk($sformatf("%s_cs", tag),       32'(cs_v[ln]),       32'd1);
      chk($sformatf("%s_sclk", tag),     32'(sclk_v[ln]),     32'd0);
      chk($sformatf("%s_mosi", tag),     32'(mosi_v[ln]),     32'd0);
      chk($sformatf("%s_tx_ready", tag), 32'(tx_ready_v[ln]), 32'd1);
      chk($sformatf("%s_rx_dat", tag),   32'(rx_dat_v[ln]),   32'd0);
      chk($sformatf("%s_done", tag),     32'(done_v[ln]),     32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] rb, sb;
      int         t;
      for (int i = 0; i < 2; i++) begin
         rst_v[i] = 1'b1; tx_valid_v[i] = 1'b0; tx_dat_v[i] = 8'h00;
         loop_v[i] = 1'b0; slave_byte[i] = 8'h00;
      end
      repeat (3) @(negedge clk);
      chk_idle_outputs("reset0", 0);
      chk_idle_outputs("reset1", 1);
      rst_v[0] = 1'b0;
      rst_v[1] = 1'b0;
      @(negedge clk);

      // A5 out, peripheral returns 96
      send(0, 8'hA5, 8'h96, 1'b0);
      wait_ready(0);

      // loopback 3C, rx_dat must hold afterwards
      send(0, 8'h3C, 8'h00, 1'b1);
      wait_ready(0);
      repeat (10) @(negedge clk);
      chk("loop_rx_hold", 32'(rx_dat_v[0]), 32'h3C);

      // back-to-back 01 then FF with tx_valid held high
      @(negedge clk);
      loop_v[0] = 1'b1;
      tx_dat_v[0] = 8'h01;
      tx_valid_v[0] = 1'b1;
      @(posedge clk);
      #1;
      qpush(0, 16'h0101);
      tx_dat_v[0] = 8'hFF;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (cs_v[0] !== 1'b1 && t < 200);
      chk("b2b_ready_at_cs_rise", 32'(tx_ready_v[0]), 32'd1);
      qpush(0, 16'hFFFF);
      @(negedge clk);
      chk("b2b_cs_high_one_cycle", 32'(cs_v[0]), 32'd0);
      tx_valid_v[0] = 1'b0;
      wait_ready(0);

      // busy: a tx_valid pulse with 00 mid-frame must be ignored
      send(0, 8'h5A, 8'h00, 1'b1);
      repeat (20) @(negedge clk);
      chk("busy_tx_ready_low", 32'(tx_ready_v[0]), 32'd0);
      tx_dat_v[0] = 8'h00;
      tx_valid_v[0] = 1'b1;
      @(negedge clk);
      tx_valid_v[0] = 1'b0;
      wait_ready(0);
      chk("busy_rx_dat", 32'(rx_dat_v[0]), 32'h5A);

      // reset during bit 4 of C3
      send(0, 8'hC3, 8'h3E, 1'b0);
      repeat (38) @(negedge clk);
      #2;
      rst_v[0] = 1'b1;
      #1;
      chk_idle_outputs("midreset", 0);
      q0.delete();
      repeat (2) @(negedge clk);
      rst_v[0] = 1'b0;
      @(negedge clk);
      send(0, 8'h81, 8'h24, 1'b0);
      wait_ready(0);

      // randomized traffic, idle gaps 0..3 cycles
      for (int k = 0; k < 16; k++) begin
         rb = 8'($urandom);
         sb = 8'($urandom);
         send(0, rb, sb, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_ready(0);

      // CLK_DIV=2 instance
      send(1, 8'h5A, 8'hA3, 1'b0);
      for (int k = 0; k < 6; k++) begin
         rb = 8'($urandom);
         sb = 8'($urandom);
         send(1, rb, sb, 1'($urandom_range(0, 1)));
      end
      wait_ready(1);

      repeat (5) @(negedge clk);
      chk("lane0_queue_drained", 32'(qsize(0)), 32'd0);
      chk("lane1_queue_drained", 32'(qsize(1)), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
